nvme_axi_id_remap: RTL and testbench
====================================

NVME_AXI_ID_REMAP -- requirements
Module: nvme_axi_id_remap

Interface
REQ-001 SHALL have parameter IN_ID_BITS, default 5: upstream (slave-side) AXI ID width.
REQ-002 SHALL have parameter OUT_ID_BITS, default 2: downstream (master-side) ID width; SLOTS = 2^OUT_ID_BITS per direction.
REQ-003 SHALL have parameter ADDR_BITS, default 64: address width, passed through.
REQ-004 SHALL have parameter DATA_BITS, default 128: data width, passed through; strobe width DATA_BITS/8.
REQ-005 SHALL have parameter MAX_OUT, default 16: outstanding bursts per slot; counter width clog2(MAX_OUT+1).
REQ-006 SHALL have port axi_aclk, input, 1: the single clock; all logic rising-edge.
REQ-007 SHALL have port axi_aresetn, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports s_axi_aw{id,addr,len,size,burst,valid,ready} and s_axi_ar{same}: upstream address channels; id is IN_ID_BITS wide, len 8, size 3, burst 2.
REQ-009 SHALL have ports m_axi_aw{...} and m_axi_ar{...}: downstream address channels with identical fields; id is OUT_ID_BITS wide.
REQ-010 SHALL have ports s_axi_w{data,strb,last,valid,ready} and m_axi_w{same}: write data, wired straight through.
REQ-011 SHALL have ports m_axi_b{id,resp,valid,ready} (in) and s_axi_b{id,resp,valid,ready} (out): write responses.
REQ-012 SHALL have ports m_axi_r{id,data,resp,last,valid,ready} (in) and s_axi_r{same} (out): read data.
REQ-013 SHALL have ports rd_slots_used and wr_slots_used, output, OUT_ID_BITS+1 each: count of valid slots.
REQ-014 SHALL have port id_err, output, 1: sticky flag, set on a response whose ID hits an invalid slot.

Function
REQ-015 SHALL keep independent read and write tables; each slot holds valid, stored in_id and count.
REQ-016 SHALL, on an address request, select a hit slot (valid, stored in_id equals request id, count < MAX_OUT), else the lowest-index free slot, else none.
REQ-017 SHALL, when request id matches a valid slot with count == MAX_OUT, select none and SHALL NOT allocate a second slot for that id; this preserves per-ID ordering.
REQ-018 SHALL drive m_axi_arvalid = s_axi_arvalid & sel_ok, s_axi_arready = m_axi_arready & sel_ok and m_axi_arid = selected slot index, all combinationally with zero latency; the AW path works the same way.
REQ-019 SHALL pass all non-ID address fields unchanged.
REQ-020 SHALL, on an address handshake, increment the selected slot's count; on a new allocation it SHALL also set valid and store in_id.
REQ-021 SHALL return s_axi_rid = table[m_axi_rid].in_id combinationally and pass data/resp/last/valid/ready straight through; the B path works the same way.
REQ-022 SHALL, on an R handshake with rlast=1 (or any B handshake), decrement that slot's count and clear valid when the count reaches 0.
REQ-023 SHALL compute slot selection from registered table state only; a slot freed in cycle N is allocatable from cycle N+1.
REQ-024 SHALL, on an address handshake and a last-response on the same slot in the same cycle, leave count unchanged and keep the slot valid.
REQ-025 SHALL, on a response to an invalid slot, output in_id 0, still complete the handshake, leave the table unchanged and set id_err until reset.
REQ-026 SHALL never let a count exceed MAX_OUT or underflow below 0.

Reset
REQ-027 SHALL, while axi_aresetn=0, clear all valid bits, counts and id_err, and force m_axi_arvalid, m_axi_awvalid, s_axi_arready and s_axi_awready to 0; W/R/B pass-through valids follow their inputs.
REQ-028 SHALL drop in-flight transactions on reset mid-operation; downstream is reset together with this block.

Verification
REQ-029 SHALL verify: AR id=0x13 len=3, then R beats rid=0 with last on beat 4 -> m_arid=0, s_rid=0x13 ×4, rd_slots_used goes 1→0 after last.
REQ-030 SHALL verify: 4 ARs with ids 1,2,3,4 (OUT_ID_BITS=2), then a 5th with id 5 -> slots 0..3 used, s_arready=0 for id 5 until one last-beat retires; id 5 is accepted the cycle after.
REQ-031 SHALL verify: 17 ARs with id 7, MAX_OUT=16 -> all use slot 0; the 17th stalls; no second slot is allocated.
REQ-032 SHALL verify: same-cycle AW handshake and B on slot 1 with count=1 -> count stays 1, slot 1 remains valid.
REQ-033 SHALL verify: B with bid=3 to an empty table -> s_bid=0, bvalid passes through, id_err=1 and stays 1.
REQ-034 SHALL verify: reset asserted with 3 outstanding reads -> slots_used=0 and id_err=0 immediately; the next AR allocates slot 0.

Source files
------------

// File: rtl/nvme_axi_id_remap.sv
// AXI ID compressor: maps wide upstream IDs onto a small pool of downstream ID
// slots per direction, tracking outstanding bursts so responses map back.
module nvme_axi_id_remap #(
  parameter int IN_ID_BITS  = 5,
  parameter int OUT_ID_BITS = 2,
  parameter int ADDR_BITS   = 64,
  parameter int DATA_BITS   = 128,
  parameter int MAX_OUT     = 16
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  // upstream AW
  input  logic [IN_ID_BITS-1:0]    s_axi_awid,
  input  logic [ADDR_BITS-1:0]     s_axi_awaddr,
  input  logic [7:0]               s_axi_awlen,
  input  logic [2:0]               s_axi_awsize,
  input  logic [1:0]               s_axi_awburst,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  // upstream AR
  input  logic [IN_ID_BITS-1:0]    s_axi_arid,
  input  logic [ADDR_BITS-1:0]     s_axi_araddr,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic [1:0]               s_axi_arburst,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  // downstream AW
  output logic [OUT_ID_BITS-1:0]   m_axi_awid,
  output logic [ADDR_BITS-1:0]     m_axi_awaddr,
  output logic [7:0]               m_axi_awlen,
  output logic [2:0]               m_axi_awsize,
  output logic [1:0]               m_axi_awburst,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  // downstream AR
  output logic [OUT_ID_BITS-1:0]   m_axi_arid,
  output logic [ADDR_BITS-1:0]     m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  // write data
  input  logic [DATA_BITS-1:0]     s_axi_wdata,
  input  logic [DATA_BITS/8-1:0]   s_axi_wstrb,
  input  logic                     s_axi_wlast,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [DATA_BITS-1:0]     m_axi_wdata,
  output logic [DATA_BITS/8-1:0]   m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  // write response
  input  logic [OUT_ID_BITS-1:0]   m_axi_bid,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [IN_ID_BITS-1:0]    s_axi_bid,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  // read data
  input  logic [OUT_ID_BITS-1:0]   m_axi_rid,
  input  logic [DATA_BITS-1:0]     m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  output logic [IN_ID_BITS-1:0]    s_axi_rid,
  output logic [DATA_BITS-1:0]     s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rlast,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  // status
  output logic [OUT_ID_BITS:0]     rd_slots_used,
  output logic [OUT_ID_BITS:0]     wr_slots_used,
  output logic                     id_err
);

  localparam int SLOTS = 1 << OUT_ID_BITS;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  // direction index: [0] = read (AR/R), [1] = write (AW/B)
  logic [1:0][IN_ID_BITS-1:0]               req_id;
  logic [1:0]                               req_vld, req_rdy_dn, req_hs, addr_ok;
  logic [1:0]                               rsp_hs, rsp_last, rsp_bad;
  logic [1:0][OUT_ID_BITS-1:0]              rsp_idx, sel_idx;
  logic [1:0]                               sel_ok;
  logic [1:0][IN_ID_BITS-1:0]               rsp_id;
  logic [1:0][OUT_ID_BITS:0]                used;
  logic [1:0][SLOTS-1:0]                    vld;
  logic [1:0][SLOTS-1:0][IN_ID_BITS-1:0]    id;
  logic [1:0][SLOTS-1:0][CNT_W-1:0]         cnt;
  logic                                     id_err_q, id_err_d;

  assign req_id     = {s_axi_awid, s_axi_arid};
  assign req_vld    = {s_axi_awvalid, s_axi_arvalid};
  assign req_rdy_dn = {m_axi_awready, m_axi_arready};
  assign rsp_hs     = {m_axi_bvalid & s_axi_bready, m_axi_rvalid & s_axi_rready};
  assign rsp_last   = {1'b1, m_axi_rlast};
  assign rsp_idx    = {m_axi_bid, m_axi_rid};

  // free slots look allocatable while in reset; gate so nothing is offered
  assign addr_ok = sel_ok & {2{axi_aresetn}};
  assign req_hs  = req_vld & req_rdy_dn & addr_ok;

  for (genvar d = 0; d < 2; d++) begin : g_dir
    logic                   hit, full, free, rsp_vld;
    logic [OUT_ID_BITS-1:0] hit_idx, free_idx;
    logic [OUT_ID_BITS:0]   pop;

    // an ID already holding a slot must stay on it, even when that slot is full
    always_comb begin
      hit      = 1'b0;
      full     = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
        if (!vld[d][i]) begin
          free     = 1'b1;
          free_idx = OUT_ID_BITS'(i);
        end
        if (vld[d][i] && id[d][i] == req_id[d]) begin
          hit     = 1'b1;
          hit_idx = OUT_ID_BITS'(i);
          full    = (cnt[d][i] == MAX_C);
        end
      end
    end

    assign sel_ok[d]  = hit ? !full : free;
    assign sel_idx[d] = hit ? hit_idx : free_idx;

    assign rsp_vld    = vld[d][rsp_idx[d]];
    assign rsp_id[d]  = rsp_vld ? id[d][rsp_idx[d]] : '0;
    assign rsp_bad[d] = rsp_hs[d] & ~rsp_vld;

    always_comb begin
      pop = '0;
      for (int i = 0; i < SLOTS; i++) pop = pop + (OUT_ID_BITS+1)'(vld[d][i]);
    end
    assign used[d] = pop;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      logic                  inc, dec;
      logic                  vld_q, vld_d;
      logic [IN_ID_BITS-1:0] id_q, id_d;
      logic [CNT_W-1:0]      cnt_q, cnt_d;

      assign inc = req_hs[d] && (sel_idx[d] == OUT_ID_BITS'(i));
      assign dec = rsp_hs[d] && rsp_last[d] && (rsp_idx[d] == OUT_ID_BITS'(i)) && vld_q;

      always_comb begin
        cnt_d = cnt_q;
        id_d  = id_q;
        if (inc && !dec && cnt_q < MAX_C)          cnt_d = cnt_q + CNT_W'(1);
        else if (dec && !inc && cnt_q != '0)       cnt_d = cnt_q - CNT_W'(1);
        if (inc && !vld_q)                         id_d  = req_id[d];
        vld_d = (cnt_d != '0);
      end

      always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
          vld_q <= 1'b0;
          id_q  <= '0;
          cnt_q <= '0;
        end else begin
          vld_q <= vld_d;
          id_q  <= id_d;
          cnt_q <= cnt_d;
        end
      end

      assign vld[d][i] = vld_q;
      assign id[d][i]  = id_q;
      assign cnt[d][i] = cnt_q;
    end
  end

  assign id_err_d = id_err_q | (|rsp_bad);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) id_err_q <= 1'b0;
    else              id_err_q <= id_err_d;
  end

  assign m_axi_arvalid = s_axi_arvalid & addr_ok[0];
  assign s_axi_arready = m_axi_arready & addr_ok[0];
  assign m_axi_arid    = sel_idx[0];
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;

  assign m_axi_awvalid = s_axi_awvalid & addr_ok[1];
  assign s_axi_awready = m_axi_awready & addr_ok[1];
  assign m_axi_awid    = sel_idx[1];
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;

  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_wvalid  = s_axi_wvalid;
  assign s_axi_wready  = m_axi_wready;

  assign s_axi_bid     = rsp_id[1];
  assign s_axi_bresp   = m_axi_bresp;
  assign s_axi_bvalid  = m_axi_bvalid;
  assign m_axi_bready  = s_axi_bready;

  assign s_axi_rid     = rsp_id[0];
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast;
  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;

  assign rd_slots_used = used[0];
  assign wr_slots_used = used[1];
  assign id_err        = id_err_q;

endmodule

// File: tb/tb_nvme_axi_id_remap.sv
// Randomized and directed checks of the ID remapper against a slot-table model.
module tb_nvme_axi_id_remap;
  localparam int IB = 5, OB = 2, AB = 64, DB = 128, MO = 16, NS = 4;

  logic axi_aclk = 1'b0;
  logic axi_aresetn = 1'b0;
  logic [IB-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AB-1:0] s_axi_awaddr, s_axi_araddr, m_axi_awaddr, m_axi_araddr;
  logic [7:0] s_axi_awlen, s_axi_arlen, m_axi_awlen, m_axi_arlen;
  logic [2:0] s_axi_awsize, s_axi_arsize, m_axi_awsize, m_axi_arsize;
  logic [1:0] s_axi_awburst, s_axi_arburst, m_axi_awburst, m_axi_arburst;
  logic s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [OB-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DB-1:0] s_axi_wdata, m_axi_wdata, m_axi_rdata, s_axi_rdata;
  logic [DB/8-1:0] s_axi_wstrb, m_axi_wstrb;
  logic s_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0] m_axi_bresp, s_axi_bresp, m_axi_rresp, s_axi_rresp;
  logic m_axi_bvalid, m_axi_bready, s_axi_bvalid, s_axi_bready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [OB:0] rd_slots_used, wr_slots_used;
  logic id_err;

  nvme_axi_id_remap #(.IN_ID_BITS(IB), .OUT_ID_BITS(OB), .ADDR_BITS(AB), .DATA_BITS(DB), .MAX_OUT(MO)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .rd_slots_used(rd_slots_used), .wr_slots_used(wr_slots_used), .id_err(id_err)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: per direction (0 = read, 1 = write) a list of slots {busy, owner id, outstanding}
  bit      mv[2][NS];
  logic [IB-1:0] mid[2][NS];
  int      mc[2][NS];
  bit      merr;

  task automatic mreset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NS; i++) begin mv[d][i] = 0; mid[d][i] = '0; mc[d][i] = 0; end
    merr = 0;
  endtask

  function automatic bit msel(input int d, input logic [IB-1:0] rid, output logic [OB-1:0] idx);
    for (int i = 0; i < NS; i++)
      if (mv[d][i] && mid[d][i] == rid) begin idx = OB'(i); return mc[d][i] < MO; end
    for (int i = 0; i < NS; i++)
      if (!mv[d][i]) begin idx = OB'(i); return 1'b1; end
    idx = '0;
    return 1'b0;
  endfunction

  function automatic int mused(input int d);
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(mv[d][i]);
    return n;
  endfunction

  task automatic mstep(input int d, input bit req, input logic [IB-1:0] rid,
                       input bit rsp, input logic [OB-1:0] ridx, input bit last);
    logic [OB-1:0] si;
    bit ok, inc, dec;
    ok  = msel(d, rid, si);
    inc = req && ok;
    dec = rsp && last && mv[d][ridx];
    if (rsp && !mv[d][ridx]) merr = 1;
    if (inc) begin
      if (!mv[d][si]) begin mv[d][si] = 1; mid[d][si] = rid; end
      mc[d][si]++;
    end
    if (dec) begin
      mc[d][ridx]--;
      if (mc[d][ridx] == 0) mv[d][ridx] = 0;
    end
  endtask

  task automatic drv(input bit arv, input logic [IB-1:0] aid, input bit rv, input logic [OB-1:0] ridx,
                     input bit rl, input bit awv, input logic [IB-1:0] wid, input bit bv,
                     input logic [OB-1:0] bidx);
    s_axi_arvalid = arv; s_axi_arid = aid; s_axi_araddr = {$urandom, $urandom};
    s_axi_arlen = 8'($urandom); s_axi_arsize = 3'($urandom); s_axi_arburst = 2'($urandom);
    s_axi_awvalid = awv; s_axi_awid = wid; s_axi_awaddr = {$urandom, $urandom};
    s_axi_awlen = 8'($urandom); s_axi_awsize = 3'($urandom); s_axi_awburst = 2'($urandom);
    m_axi_rvalid = rv; m_axi_rid = ridx; m_axi_rlast = rl; m_axi_rresp = 2'($urandom);
    m_axi_rdata = {$urandom, $urandom, $urandom, $urandom};
    m_axi_bvalid = bv; m_axi_bid = bidx; m_axi_bresp = 2'($urandom);
    #2;
  endtask

  task automatic idle();
    drv(0, '0, 0, '0, 0, 0, '0, 0, '0);
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    if (axi_aresetn) begin
      mstep(0, s_axi_arvalid && m_axi_arready, s_axi_arid, m_axi_rvalid && s_axi_rready, m_axi_rid, m_axi_rlast);
      mstep(1, s_axi_awvalid && m_axi_awready, s_axi_awid, m_axi_bvalid && s_axi_bready, m_axi_bid, 1'b1);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < NS; i++)
      while (mv[0][i] || mv[1][i]) begin
        drv(0, '0, mv[0][i], OB'(i), 1, 0, '0, mv[1][i], OB'(i));
        tick();
      end
    idle();
  endtask

  task automatic test_reset();
    drv(1, 5'h3, 1, 2'd1, 1, 1, 5'h4, 1, 2'd2);
    s_axi_wvalid = 1'b1;
    #1;
    n_tests++; if (m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got %b exp 0", m_axi_arvalid); end
    n_tests++; if (s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready got %b exp 0", s_axi_arready); end
    n_tests++; if (m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid got %b exp 0", m_axi_awvalid); end
    n_tests++; if (s_axi_awready !== 1'b0) begin n_fail++; $display("FAIL rst_awready got %b exp 0", s_axi_awready); end
    n_tests++; if (m_axi_wvalid !== 1'b1) begin n_fail++; $display("FAIL rst_wvalid got %b exp 1", m_axi_wvalid); end
    n_tests++; if (s_axi_rvalid !== 1'b1) begin n_fail++; $display("FAIL rst_rvalid got %b exp 1", s_axi_rvalid); end
    tick();
    n_tests++; if (rd_slots_used !== 3'd0 || wr_slots_used !== 3'd0) begin n_fail++; $display("FAIL rst_used got %0d/%0d exp 0/0", rd_slots_used, wr_slots_used); end
    n_tests++; if (id_err !== 1'b0) begin n_fail++; $display("FAIL rst_id_err got %b exp 0", id_err); end
    idle();
    s_axi_wvalid = 1'b0;
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    drv(1, 5'h13, 0, '0, 0, 0, '0, 0, '0);
    s_axi_arlen = 8'd3;
    #1;
    n_tests++; if (m_axi_arvalid !== 1'b1 || s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL sr_hs got %b%b exp 11", m_axi_arvalid, s_axi_arready); end
    n_tests++; if (m_axi_arid !== 2'd0) begin n_fail++; $display("FAIL sr_arid got %0d exp 0", m_axi_arid); end
    n_tests++; if (m_axi_arlen !== 8'd3 || m_axi_araddr !== s_axi_araddr) begin n_fail++; $display("FAIL sr_fields got len %0d addr %h exp len 3 addr %h", m_axi_arlen, m_axi_araddr, s_axi_araddr); end
    tick();
    for (int b = 0; b < 4; b++) begin
      drv(0, '0, 1, 2'd0, b == 3, 0, '0, 0, '0);
      n_tests++; if (s_axi_rid !== 5'h13) begin n_fail++; $display("FAIL sr_rid beat %0d got %h exp 13", b, s_axi_rid); end
      n_tests++; if (s_axi_rdata !== m_axi_rdata || s_axi_rlast !== (b == 3)) begin n_fail++; $display("FAIL sr_pass beat %0d got last %b exp %b", b, s_axi_rlast, b == 3); end
      n_tests++; if (rd_slots_used !== 3'd1) begin n_fail++; $display("FAIL sr_used beat %0d got %0d exp 1", b, rd_slots_used); end
      tick();
    end
    n_tests++; if (rd_slots_used !== 3'd0) begin n_fail++; $display("FAIL sr_used_after got %0d exp 0", rd_slots_used); end
    idle();
  endtask

  task automatic test_slots_full();
    for (int i = 1; i <= 4; i++) begin
      drv(1, IB'(i), 0, '0, 0, 0, '0, 0, '0);
      n_tests++; if (m_axi_arid !== OB'(i - 1) || s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL sf_alloc id %0d got slot %0d rdy %b exp slot %0d rdy 1", i, m_axi_arid, s_axi_arready, i - 1); end
      tick();
    end
    n_tests++; if (rd_slots_used !== 3'd4) begin n_fail++; $display("FAIL sf_used got %0d exp 4", rd_slots_used); end
    drv(1, 5'd5, 0, '0, 0, 0, '0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (s_axi_arready !== 1'b0 || m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL sf_stall cyc %0d got rdy %b vld %b exp 0 0", k, s_axi_arready, m_axi_arvalid); end
      tick();
    end
    drv(1, 5'd5, 1, 2'd2, 1, 0, '0, 0, '0);
    n_tests++; if (s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL sf_same_cyc got rdy %b exp 0", s_axi_arready); end
    tick();
    n_tests++; if (s_axi_arready !== 1'b1 || m_axi_arid !== 2'd2) begin n_fail++; $display("FAIL sf_reuse got rdy %b slot %0d exp 1 slot 2", s_axi_arready, m_axi_arid); end
    drv(1, 5'd5, 0, '0, 0, 0, '0, 0, '0);
    tick();
    drain();
  endtask

  task automatic test_max_out();
    for (int k = 0; k < MO; k++) begin
      drv(1, 5'd7, 0, '0, 0, 0, '0, 0, '0);
      n_tests++; if (m_axi_arid !== 2'd0 || s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL mo_acc %0d got slot %0d rdy %b exp 0 1", k, m_axi_arid, s_axi_arready); end
      tick();
    end
    drv(1, 5'd7, 0, '0, 0, 0, '0, 0, '0);
    n_tests++; if (s_axi_arready !== 1'b0 || m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL mo_17th got rdy %b vld %b exp 0 0", s_axi_arready, m_axi_arvalid); end
    tick();
    n_tests++; if (rd_slots_used !== 3'd1 || s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL mo_noalloc got used %0d rdy %b exp 1 0", rd_slots_used, s_axi_arready); end
    drain();
  endtask

  task automatic test_same_cycle();
    drv(0, '0, 0, '0, 0, 1, 5'd9, 0, '0);  tick();
    drv(0, '0, 0, '0, 0, 1, 5'd10, 0, '0); tick();
    drv(0, '0, 0, '0, 0, 1, 5'd10, 1, 2'd1);
    n_tests++; if (s_axi_awready !== 1'b1 || m_axi_awid !== 2'd1) begin n_fail++; $display("FAIL sc_aw got rdy %b slot %0d exp 1 1", s_axi_awready, m_axi_awid); end
    n_tests++; if (s_axi_bid !== 5'd10 || s_axi_bvalid !== 1'b1) begin n_fail++; $display("FAIL sc_bid got %0d exp 10", s_axi_bid); end
    tick();
    n_tests++; if (wr_slots_used !== 3'd2) begin n_fail++; $display("FAIL sc_used got %0d exp 2", wr_slots_used); end
    drv(0, '0, 0, '0, 0, 0, '0, 1, 2'd1); tick();
    n_tests++; if (wr_slots_used !== 3'd1) begin n_fail++; $display("FAIL sc_cnt1 got %0d exp 1", wr_slots_used); end
    drain();
  endtask

  task automatic test_id_err();
    drv(0, '0, 0, '0, 0, 0, '0, 1, 2'd3);
    n_tests++; if (s_axi_bid !== 5'd0 || s_axi_bvalid !== 1'b1 || m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL ie_pass got bid %0d vld %b rdy %b exp 0 1 1", s_axi_bid, s_axi_bvalid, m_axi_bready); end
    n_tests++; if (id_err !== 1'b0) begin n_fail++; $display("FAIL ie_pre got %b exp 0", id_err); end
    tick();
    n_tests++; if (id_err !== 1'b1 || wr_slots_used !== 3'd0) begin n_fail++; $display("FAIL ie_set got err %b used %0d exp 1 0", id_err, wr_slots_used); end
    idle();
    repeat (3) tick();
    n_tests++; if (id_err !== 1'b1) begin n_fail++; $display("FAIL ie_sticky got %b exp 1", id_err); end
  endtask

  task automatic test_random();
    logic [OB-1:0] si;
    bit ok;
    for (int c = 0; c < 400; c++) begin
      drv($urandom_range(0, 1), IB'($urandom_range(0, 5)), $urandom_range(0, 1), OB'($urandom_range(0, 3)),
          $urandom_range(0, 1), $urandom_range(0, 1), IB'($urandom_range(0, 5)), $urandom_range(0, 2) == 0,
          OB'($urandom_range(0, 3)));
      ok = msel(0, s_axi_arid, si);
      n_tests++; if (s_axi_arready !== ok || m_axi_arvalid !== (s_axi_arvalid && ok)) begin n_fail++; $display("FAIL rnd_ar c%0d got rdy %b exp %b", c, s_axi_arready, ok); end
      n_tests++; if (ok && m_axi_arid !== si) begin n_fail++; $display("FAIL rnd_arid c%0d got %0d exp %0d", c, m_axi_arid, si); end
      n_tests++; if (s_axi_rid !== (mv[0][m_axi_rid] ? mid[0][m_axi_rid] : 5'd0)) begin n_fail++; $display("FAIL rnd_rid c%0d got %0d", c, s_axi_rid); end
      n_tests++; if (int'(rd_slots_used) != mused(0)) begin n_fail++; $display("FAIL rnd_rused c%0d got %0d exp %0d", c, rd_slots_used, mused(0)); end
      ok = msel(1, s_axi_awid, si);
      n_tests++; if (s_axi_awready !== ok || m_axi_awvalid !== (s_axi_awvalid && ok)) begin n_fail++; $display("FAIL rnd_aw c%0d got rdy %b exp %b", c, s_axi_awready, ok); end
      n_tests++; if (ok && m_axi_awid !== si) begin n_fail++; $display("FAIL rnd_awid c%0d got %0d exp %0d", c, m_axi_awid, si); end
      n_tests++; if (s_axi_bid !== (mv[1][m_axi_bid] ? mid[1][m_axi_bid] : 5'd0)) begin n_fail++; $display("FAIL rnd_bid c%0d got %0d", c, s_axi_bid); end
      n_tests++; if (int'(wr_slots_used) != mused(1)) begin n_fail++; $display("FAIL rnd_wused c%0d got %0d exp %0d", c, wr_slots_used, mused(1)); end
      n_tests++; if (id_err !== merr) begin n_fail++; $display("FAIL rnd_err c%0d got %b exp %b", c, id_err, merr); end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin drv(1, IB'(i + 8), 0, '0, 0, 0, '0, 0, '0); tick(); end
    n_tests++; if (rd_slots_used !== 3'd3) begin n_fail++; $display("FAIL rm_pre got %0d exp 3", rd_slots_used); end
    axi_aresetn = 1'b0;
    mreset();
    #1;
    n_tests++; if (rd_slots_used !== 3'd0 || id_err !== 1'b0) begin n_fail++; $display("FAIL rm_clear got used %0d err %b exp 0 0", rd_slots_used, id_err); end
    n_tests++; if (m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL rm_arvalid got %b exp 0", m_axi_arvalid); end
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    drv(1, 5'h1f, 0, '0, 0, 0, '0, 0, '0);
    n_tests++; if (m_axi_arvalid !== 1'b1 || m_axi_arid !== 2'd0) begin n_fail++; $display("FAIL rm_realloc got vld %b slot %0d exp 1 0", m_axi_arvalid, m_axi_arid); end
    tick();
    n_tests++; if (rd_slots_used !== 3'd1) begin n_fail++; $display("FAIL rm_used got %0d exp 1", rd_slots_used); end
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    mreset();
    m_axi_arready = 1'b1; m_axi_awready = 1'b1; s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    m_axi_wready = 1'b1; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0;
    test_reset();
    test_single_read();
    test_slots_full();
    test_max_out();
    test_same_cycle();
    test_id_err();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
